// File: rtl/sbox_pkg.sv
// sbox_pkg: shared types and defaults for the S-box build sequencer.
//   state_e        build FSM states
//   *_DEF          default parameter values for the sequencer and its interface
//   SBOX_DEPTH     table depth for the default element width
//   REJ_W          width of the duplicate counter
//   cnt_w()        bits needed to hold 0..max_val
package sbox_pkg;
    localparam int PRECISION_DEF    = 32;
    localparam int BIT_WIDTH_DEF    = 8;
    localparam int TIMEOUT_DEF      = 1024;
    localparam int MAX_ATTEMPTS_DEF = 65535;
    localparam int SBOX_DEPTH       = 2 ** BIT_WIDTH_DEF;
    localparam int REJ_W            = 16;

    typedef enum logic [2:0] {
        IDLE, REQ_PRNG, WAIT_PRNG, REQ_GEN, WAIT_GEN, CHECK, DONE, ERROR
    } state_e;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/sbox_build_ctrl_if.sv
// sbox_build_ctrl_if: PRNG, generator and table-write signals of the S-box builder.
//   prng_tvalid/prng_valid/prng_num1..3   request and result of the PRNG
//   gen_tvalid/gen_num1..3/gen_valid/gen_v request and candidate of sbox_generator
//   sbox_we/sbox_waddr/sbox_wdata         S-box RAM write port
//   master = sequencer side, slave = environment side
interface sbox_build_ctrl_if import sbox_pkg::*; #(
    parameter int PRECISION = PRECISION_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF
);
    logic                 prng_tvalid;
    logic                 prng_valid;
    logic [PRECISION-1:0] prng_num1, prng_num2, prng_num3;
    logic                 gen_tvalid;
    logic [PRECISION-1:0] gen_num1, gen_num2, gen_num3;
    logic                 gen_valid;
    logic [BIT_WIDTH-1:0] gen_v;
    logic                 sbox_we;
    logic [BIT_WIDTH-1:0] sbox_waddr, sbox_wdata;

    modport master (
        output prng_tvalid, input prng_valid, prng_num1, prng_num2, prng_num3,
        output gen_tvalid, gen_num1, gen_num2, gen_num3, input gen_valid, gen_v,
        output sbox_we, sbox_waddr, sbox_wdata
    );
    modport slave (
        input prng_tvalid, output prng_valid, prng_num1, prng_num2, prng_num3,
        input gen_tvalid, gen_num1, gen_num2, gen_num3, output gen_valid, gen_v,
        input sbox_we, sbox_waddr, sbox_wdata
    );
endinterface

// File: rtl/sbox_used_bitmap.sv
// sbox_used_bitmap: one flag per S-box value, marking values already placed.
//   clk, rst   clock and synchronous active-high reset
//   clr_i      clear every flag in one cycle (wins over set_i)
//   set_i      mark v_i as used
//   v_i        value under test / to set
//   used_o     combinational flag of v_i
module sbox_used_bitmap import sbox_pkg::*; #(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DEPTH     = SBOX_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 set_i,
    input  logic [BIT_WIDTH-1:0] v_i,
    output logic                 used_o
);
    logic [DEPTH-1:0] used_q;

    assign used_o = used_q[v_i];

    always_ff @(posedge clk) begin
        if (rst || clr_i)
            used_q <= '0;
        else if (set_i)
            used_q[v_i] <= 1'b1;
    end
endmodule

// File: rtl/sbox_build_ctrl.sv
// sbox_build_ctrl: sequences PRNG -> sbox_generator attempts until a bijective S-box is written.
//   clk, reset_n   clock and synchronous reset (active-high despite the name)
//   start          build request, honoured only in IDLE/DONE/ERROR
//   bus            PRNG / generator handshakes and S-box table write port
//   busy           build in progress
//   done, error    level status of the last build (table complete / timeout or attempt overflow)
//   reject_cnt     duplicate candidates seen this build, saturating
module sbox_build_ctrl import sbox_pkg::*; #(
    parameter int PRECISION    = PRECISION_DEF,
    parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    sbox_build_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [REJ_W-1:0]  reject_cnt
);
    localparam int WAIT_W = cnt_w(TIMEOUT);
    // One spare bit so unique candidates past MAX_ATTEMPTS cannot wrap the counter.
    localparam int ATT_W  = cnt_w(MAX_ATTEMPTS) + 1;
    localparam logic [BIT_WIDTH-1:0] LAST = BIT_WIDTH'(2 ** BIT_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   cnt_q, cnt_d, v_q, v_d;
    logic [ATT_W-1:0]       att_q, att_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [REJ_W-1:0]       rej_q, rej_d;
    logic [PRECISION-1:0]   n1_q, n1_d, n2_q, n2_d, n3_q, n3_d;
    logic                   clr, set, used;

    sbox_used_bitmap #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(2 ** BIT_WIDTH)) u_used (
        .clk    (clk),
        .rst    (reset_n),
        .clr_i  (clr),
        .set_i  (set),
        .v_i    (v_q),
        .used_o (used)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            att_q   <= '0;
            wait_q  <= '0;
            rej_q   <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            n3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            att_q   <= att_d;
            wait_q  <= wait_d;
            rej_q   <= rej_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            n3_q    <= n3_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        att_d   = att_q;
        wait_d  = wait_q;
        rej_d   = rej_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        n3_d    = n3_q;
        clr     = 1'b0;
        set     = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d = REQ_PRNG;
                clr     = 1'b1;
                cnt_d   = '0;
                att_d   = '0;
                rej_d   = '0;
            end
            REQ_PRNG, REQ_GEN: begin
                wait_d  = '0;
                state_d = state_q == REQ_PRNG ? WAIT_PRNG : WAIT_GEN;
            end
            // A strobe in the expiry cycle is still accepted: valid is tested first.
            WAIT_PRNG: if (bus.prng_valid) begin
                n1_d    = bus.prng_num1;
                n2_d    = bus.prng_num2;
                n3_d    = bus.prng_num3;
                state_d = REQ_GEN;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1))
                state_d = ERROR;
            else
                wait_d = wait_q + WAIT_W'(1);
            WAIT_GEN: if (bus.gen_valid) begin
                v_d     = bus.gen_v;
                att_d   = att_q + ATT_W'(1);
                state_d = CHECK;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1))
                state_d = ERROR;
            else
                wait_d = wait_q + WAIT_W'(1);
            CHECK: if (!used) begin
                set     = 1'b1;
                state_d = cnt_q == LAST ? DONE : REQ_PRNG;
                cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + BIT_WIDTH'(1);
            end else begin
                rej_d   = &rej_q ? rej_q : rej_q + REJ_W'(1);
                state_d = att_q >= ATT_W'(MAX_ATTEMPTS) ? ERROR : REQ_PRNG;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy            = !(state_q inside {IDLE, DONE, ERROR});
    assign done            = state_q == DONE;
    assign error           = state_q == ERROR;
    assign reject_cnt      = rej_q;
    assign bus.prng_tvalid = state_q == REQ_PRNG;
    assign bus.gen_tvalid  = state_q == REQ_GEN;
    assign bus.gen_num1    = n1_q;
    assign bus.gen_num2    = n2_q;
    assign bus.gen_num3    = n3_q;
    assign bus.sbox_we     = state_q == CHECK && !used;
    assign bus.sbox_waddr  = cnt_q;
    assign bus.sbox_wdata  = v_q;
endmodule

// File: doc/sbox_build_ctrl.md
Name: sbox_build_ctrl

Overview:
- Sequencer that builds one complete bijective 256-entry S-box from the chaotic pipeline PRNG → sbox_generator.
- Per attempt: requests a PRNG triple, hands it to sbox_generator, receives one candidate byte, rejects it if already present, else writes it to the S-box table.
- Sits between top-level start control and the S-box RAM write port; replaces the free-running valid chaining in the top level.

Parameters:
- PRECISION, 32, width of each pseudo-random number
- BIT_WIDTH, 8, S-box element width; table depth = 2**BIT_WIDTH
- TIMEOUT, 1024, max cycles waiting on prng_valid or gen_valid
- MAX_ATTEMPTS, 65535, max candidate bytes consumed per build

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-high reset (name kept per codebase convention; asserted = 1)
- start  in  1  build request; sampled only in IDLE/DONE/ERROR
- prng_tvalid  out  1  one-cycle request to PRNG
- prng_valid  in  1  PRNG result strobe
- prng_num1/2/3  in  PRECISION  PRNG outputs
- gen_tvalid  out  1  one-cycle request to sbox_generator
- gen_num1/2/3  out  PRECISION  registered triple to generator
- gen_valid  in  1  generator result strobe
- gen_v  in  BIT_WIDTH  candidate byte
- sbox_we  out  1  table write enable
- sbox_waddr  out  BIT_WIDTH  table index
- sbox_wdata  out  BIT_WIDTH  table value
- busy  out  1  build in progress
- done  out  1  table complete (level)
- error  out  1  timeout or attempt overflow (level)
- reject_cnt  out  16  duplicate candidates this build

Behaviour:
- Reset: state IDLE; every output 0; used bitmap, count, attempt, wait counters cleared. Reset mid-build aborts with no further writes.
- States: IDLE, REQ_PRNG, WAIT_PRNG, REQ_GEN, WAIT_GEN, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start=1: clear bitmap, count, attempt, reject_cnt, done, error; busy=1; go to REQ_PRNG next cycle.
- REQ_PRNG: prng_tvalid=1 for exactly one cycle → WAIT_PRNG; wait counter cleared.
- WAIT_PRNG: prng_valid=1 → latch prng_num1..3 into gen_num1..3 → REQ_GEN. Wait counter reaches TIMEOUT → ERROR.
- REQ_GEN: gen_tvalid=1 for one cycle, gen_num stable → WAIT_GEN. gen_num holds until the next latch.
- WAIT_GEN: gen_valid=1 → latch gen_v, attempt+1 → CHECK. Same TIMEOUT rule → ERROR.
- CHECK (one cycle):
  - If used[v]=0: sbox_we=1, waddr=count, wdata=v, used[v]=1. If count==2**BIT_WIDTH-1 → DONE, else count+1 → REQ_PRNG.
  - If used[v]=1: no write, reject_cnt+1 (saturates at 0xFFFF). If attempt==MAX_ATTEMPTS → ERROR, else REQ_PRNG.
- DONE: done=1, busy=0, held until start or reset. ERROR: error=1, busy=0, held likewise.
- Writes are strictly sequential addresses 0..255, exactly 256 per successful build, all values distinct.
- prng_valid/gen_valid outside their WAIT state are ignored. start while busy is ignored.
- Valid arriving in the same cycle as the timeout expiry: the valid wins.
- Minimum attempt latency is 5 cycles plus PRNG and generator latency.

Decomposition:
- Package sbox_pkg: state enum, SBOX_DEPTH = 2**BIT_WIDTH, counter widths.
- Sub-module sbox_used_bitmap:
  - 256-bit register with single-cycle clear, combinational test(v), and set(v).
  - Clear has priority over set.

Test Plan:
- Stub generator returns 0..255 in order → 256 writes with addr=i, data=i; done=1 one cycle after the last write; reject_cnt=0.
- Stub returns 5,5,7 then the remaining values → addr0=5, addr1=7; reject_cnt increments once, no write on the duplicate.
- PRNG stub never asserts prng_valid, TIMEOUT=16 → error=1 after 16 wait cycles; busy=0; no gen_tvalid ever issued.
- MAX_ATTEMPTS=4, stub always returns 9 → one write (addr0=9), 3 rejects, error=1 after attempt 4.
- reset_n pulsed high after 10 writes, then start → write sequence restarts at addr0; bitmap cleared, so a previously used value is accepted.
- start pulsed during WAIT_GEN plus a spurious prng_valid in REQ_GEN → no restart, no extra prng_tvalid, build completes normally.
